uart_rx_module: RTL and testbench
=================================

// Module: uart_rx_module
// PURPOSE
//  UART receiver: recovers 8N1-style frames from asynchronous serial input i_uart_rx and presents each byte
//  as a one-cycle valid pulse. Receiving end of the link whose transmitter sits on the same board.
//  Placed after the power-on reset generator; i_rst is driven by that block's output.
// PARAMETERS
//  P_CLK_FREQ     50_000_000  system clock frequency, Hz
//  P_BAUD         115_200     line rate, bit/s; CPB = P_CLK_FREQ / P_BAUD (integer divide), CPB >= 4
//  P_DATA_WIDTH   8           data bits per frame, 5..8, LSB first
//  P_STOP_WIDTH   1           stop bits checked, 1 or 2
//  P_PARITY_ODD   0           0 = even parity, 1 = odd (only used with UART_RX_PARITY_EN)
// PORTS
//  i_clk          in   1               system clock, all logic on rising edge
//  i_rst          in   1               synchronous reset, active-high
//  i_uart_rx      in   1               asynchronous serial line, idle high
//  o_rx_data      out  P_DATA_WIDTH    last received data word
//  o_rx_valid     out  1               one-cycle pulse: o_rx_data holds a new, good frame
//  o_frame_err    out  1               one-cycle pulse: stop bit sampled low
//  o_parity_err   out  1               one-cycle pulse: parity mismatch (tied 0 without macro)
//  o_busy         out  1               high while state != IDLE
// BEHAVIOUR
//  - One clock, i_clk; reset synchronous active-high. Reset: o_rx_data=0, o_rx_valid=0, o_frame_err=0,
//    o_parity_err=0, o_busy=0, state=IDLE, synchroniser FFs=1, bit counter=0, cycle counter=0.
//  - i_uart_rx passes a 2-FF synchroniser (reset to 1) plus one delay FF for edge detect; 2-cycle input latency.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: falling edge on synchronised line -> START, cycle counter cleared.
//  - START: at cnt == CPB/2-1 sample line; 0 -> DATA (cnt cleared); 1 -> IDLE (glitch, no error pulse).
//  - DATA: sample at cnt == CPB-1 (mid-bit), shift into data reg LSB first; after P_DATA_WIDTH bits -> PARITY/STOP.
//  - PARITY: sample at cnt == CPB-1; compare with XOR(data) ^ P_PARITY_ODD; mismatch latched.
//  - STOP: sample each stop bit at cnt == CPB-1. Any stop sample 0 -> frame error.
//    After last stop sample -> IDLE same cycle (half-bit early, allows back-to-back frames).
//  - Output cycle (cycle after last stop sample): o_rx_data <= shift reg always;
//    good frame -> o_rx_valid=1; bad stop -> o_frame_err=1, o_rx_valid=0; parity error -> o_parity_err=1,
//    o_rx_valid=0. Frame and parity error may pulse together. Pulses exactly 1 cycle.
//  - Latency: o_rx_valid rises 2 + CPB/2 + (P_DATA_WIDTH+P_STOP_WIDTH[+1])*CPB + 1 cycles after line fall.
//  - Break (line held low): frame error once, then IDLE waits for a new falling edge (needs line to go high).
//  - Counters: cycle counter width $clog2(CPB)+1, never wraps past CPB-1; bit counter 4 bits.
//  - i_rst mid-frame: immediate abort to IDLE, no pulses, partial data discarded.
//  - o_busy = (state != IDLE), registered with state.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state inserted after DATA, o_parity_err driven per P_PARITY_ODD.
//  UART_RX_PARITY_EN undefined: no PARITY state, frame = start+data+stop, o_parity_err tied 0,
//    P_PARITY_ODD ignored.
// TESTING (P_CLK_FREQ=50_000_000, P_BAUD=5_000_000 -> CPB=10, defaults otherwise)
//  1. Send 0xA5, 8N1, exact timing -> single o_rx_valid pulse, o_rx_data=8'hA5, no error pulses, o_busy low after.
//  2. Back-to-back 0x00,0xFF,0x3C with no idle gap -> three valid pulses, data in order, none lost.
//  3. 3-cycle low glitch in idle -> returns to IDLE from START, no pulses, o_rx_data unchanged.
//  4. 0x55 with stop bit forced 0 -> o_frame_err pulse, o_rx_valid=0, o_rx_data=8'h55; line low 30 bit-times
//     -> no further pulses until line goes high and a new frame arrives.
//  5. i_rst asserted for 1 cycle in bit 4 of 0x81, then clean 0x42 -> no pulse for 0x81, valid with 8'h42.
//  6. With UART_RX_PARITY_EN, even: 0x07 with parity 1 -> valid; parity 0 -> o_parity_err pulse, no valid.

Source files
------------

// File: rtl/uart_rx_module.sv
// ---------------------------------------------------------------------------
// uart_rx_module
//   UART receiver. Recovers start/data/[parity]/stop frames from the
//   asynchronous serial line and presents each received word together with
//   one-cycle status pulses.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> a parity bit follows the data bits and is checked against
//                  XOR(data) ^ P_PARITY_ODD; mismatches pulse o_parity_err.
//     undefined -> frame is start + data + stop, o_parity_err stays 0.
//
// Ports
//   i_clk         system clock, all logic on the rising edge
//   i_rst         synchronous reset, active-high
//   i_uart_rx     asynchronous serial input, idles high
//   o_rx_data     last received data word (LSB first on the line)
//   o_rx_valid    one-cycle pulse: o_rx_data holds a new, error-free word
//   o_frame_err   one-cycle pulse: a stop bit was sampled low
//   o_parity_err  one-cycle pulse: parity mismatch
//   o_busy        high while the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_module #(
  parameter int P_CLK_FREQ   = 50_000_000,
  parameter int P_BAUD       = 115_200,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_STOP_WIDTH = 1,
  parameter int P_PARITY_ODD = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_uart_rx,
  output logic [P_DATA_WIDTH-1:0] o_rx_data,
  output logic                    o_rx_valid,
  output logic                    o_frame_err,
  output logic                    o_parity_err,
  output logic                    o_busy
);

  localparam int CPB   = P_CLK_FREQ / P_BAUD;
  localparam int CNT_W = $clog2(CPB) + 1;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, state_nxt;
  logic                    rx_sync1, rx_sync2, rx_prev;
  logic                    rx_fall;
  logic [CNT_W-1:0]        cnt;
  logic [3:0]              bit_cnt;
  logic [P_DATA_WIDTH-1:0] shift;
  logic                    frame_bad, parity_bad;
  logic                    half_tick, bit_tick, frame_done;
  logic                    valid_nxt, ferr_nxt, perr_nxt;

  // Two-stage synchroniser plus one delay stage for falling-edge detection.
  // Reset to 1 so a reset never looks like a start bit on an idle line.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= i_uart_rx;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  assign rx_fall    = rx_prev & ~rx_sync2;
  assign half_tick  = (cnt == CNT_W'(CPB/2 - 1));
  assign bit_tick   = (cnt == CNT_W'(CPB - 1));
  assign frame_done = (state == STOP) && bit_tick &&
                      (bit_cnt == 4'(P_STOP_WIDTH - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (rx_fall) state_nxt = START;
      // A line back high at mid start bit was a glitch: quietly drop it.
      START:  if (half_tick) state_nxt = rx_sync2 ? IDLE : DATA;
      DATA:   if (bit_tick && bit_cnt == 4'(P_DATA_WIDTH - 1))
                state_nxt = PAR_EN ? PARITY : STOP;
      PARITY: if (bit_tick) state_nxt = STOP;
      // Leaving at mid stop bit gives half a bit of slack for the next start.
      STOP:   if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode for the cycle after the last stop sample
  always_comb begin
    ferr_nxt  = frame_done && (frame_bad || !rx_sync2);
    perr_nxt  = frame_done && PAR_EN && parity_bad;
    valid_nxt = frame_done && !ferr_nxt && !perr_nxt;
  end

  // Counters and shift register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      frame_bad  <= 1'b0;
      parity_bad <= 1'b0;
    end else begin
      // Cycle counter restarts on every state change and every bit period,
      // so it never runs past CPB-1.
      if (state == IDLE || state_nxt != state || bit_tick) cnt <= '0;
      else                                                   cnt <= cnt + 1'b1;

      if (state_nxt != state)                                  bit_cnt <= '0;
      else if (bit_tick && (state == DATA || state == STOP))  bit_cnt <= bit_cnt + 1'b1;

      if (state == DATA && bit_tick)
        shift <= {rx_sync2, shift[P_DATA_WIDTH-1:1]};

      if (state == IDLE) begin
        frame_bad  <= 1'b0;
        parity_bad <= 1'b0;
      end else begin
        if (state == STOP && bit_tick && !rx_sync2)
          frame_bad <= 1'b1;
        if (state == PARITY && bit_tick)
          parity_bad <= rx_sync2 ^ (^shift) ^ P_PARITY_ODD[0];
      end
    end
  end

  // Registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      if (frame_done) o_rx_data <= shift;
      o_rx_valid   <= valid_nxt;
      o_frame_err  <= ferr_nxt;
      o_parity_err <= perr_nxt;
      o_busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_module.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_module
//   Self-checking bench for uart_rx_module at CPB = 10. A serial driver
//   builds frames bit by bit and pushes the expected outcome of each frame
//   into a queue; an independent monitor pops and compares on every output
//   pulse. Directed cases are followed by randomized frames.
// ---------------------------------------------------------------------------
module tb_uart_rx_module;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 5_000_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int DW       = 8;
  localparam int SW       = 1;
  localparam int PODD     = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [DW-1:0] rx_data;
  logic          rx_valid, frame_err, parity_err, busy;

  uart_rx_module #(
    .P_CLK_FREQ  (CLK_FREQ),
    .P_BAUD      (BAUD),
    .P_DATA_WIDTH(DW),
    .P_STOP_WIDTH(SW),
    .P_PARITY_ODD(PODD)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_uart_rx   (rx),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .o_frame_err (frame_err),
    .o_parity_err(parity_err),
    .o_busy      (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         ferr;
    bit         perr;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         fails  = 0;
  int         cyc    = 0;
  int         pulse_cyc = 0;
  logic [7:0] last_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every status pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rx_valid || frame_err || parity_err)) begin
      pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: valid=%0b ferr=%0b perr=%0b data=0x%0h with nothing pending",
                 rx_valid, frame_err, parity_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_data",    rx_data,    e.data);
        check("rx_valid",   rx_valid,   !(e.ferr || e.perr));
        check("frame_err",  frame_err,  e.ferr);
        check("parity_err", parity_err, e.perr);
      end
    end
  end

  // Line driver helpers; all start and end on a falling clock edge.
  task automatic line(input logic b, input int cycles);
    rx = b;
    repeat (cycles) @(negedge clk);
  endtask

  // Sends one frame and records the outcome the receiver must report,
  // derived from the bits as they go on the wire.
  task automatic send_frame(input logic [7:0] d, input bit bad_stop,
                            input bit bad_par, input int gap_bits);
    exp_t       e;
    logic       par_bit;
    logic [1:0] stops;
    par_bit = (^d) ^ PODD[0] ^ bad_par;
    stops   = bad_stop ? 2'b10 : 2'b11;
    e.data  = d;
    e.ferr  = 1'b0;
    for (int i = 0; i < SW; i++) if (stops[i] == 1'b0) e.ferr = 1'b1;
    e.perr  = (PBITS != 0) && (par_bit != ((^d) ^ PODD[0]));
    exp_q.push_back(e);
    last_data = d;
    line(1'b0, CPB);
    for (int i = 0; i < DW; i++) line(d[i], CPB);
    if (PBITS != 0) line(par_bit, CPB);
    for (int i = 0; i < SW; i++) line(stops[i], CPB);
    if (gap_bits > 0) line(1'b1, gap_bits * CPB);
  endtask

  // Bounded wait for all outstanding frames to be reported.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int start_cyc;
    int gap;
    bit bad_s, bad_p;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",  rx_data,  0);
    check("reset_valid", rx_valid, 0);
    check("reset_busy",  busy,     0);
    check("reset_ferr",  frame_err, 0);
    rst = 1'b0;
    line(1'b1, 2 * CPB);

    // 1: single clean frame, plus end-to-end latency from the line fall.
    start_cyc = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 2);
    drain("t1");
    check("t1_latency", pulse_cyc - start_cyc,
          2 + CPB/2 + (DW + SW + PBITS) * CPB + 1);
    check("t1_busy", busy, 0);

    // 2: back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b0, 0);
    send_frame(8'hFF, 1'b0, 1'b0, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 2);
    drain("t2");

    // 3: 3-cycle glitch while idle must be ignored.
    line(1'b0, 3);
    line(1'b1, 3 * CPB);
    check("t3_busy", busy, 0);
    check("t3_data_kept", rx_data, last_data);

    // 4: bad stop bit followed by a long break, then release.
    send_frame(8'h55, 1'b1, 1'b0, 0);
    line(1'b0, 30 * CPB);
    drain("t4");
    line(1'b1, 2 * CPB);
    check("t4_busy", busy, 0);

    // 5: reset in the middle of data bit 4 of 0x81. The transmitter shares
    // the board reset, so the line returns to idle along with it.
    line(1'b0, CPB);
    for (int i = 0; i < 4; i++) line(1'(8'h81 >> i), CPB);
    line(1'b0, CPB/2);
    rst = 1'b1;
    line(1'b1, 1);
    rst = 1'b0;
    check("t5_busy_after_rst", busy, 0);
    check("t5_data_after_rst", rx_data, 0);
    line(1'b1, 12 * CPB);
    check("t5_idle", busy, 0);
    send_frame(8'h42, 1'b0, 1'b0, 2);
    drain("t5");

    // 6: parity good then bad (only meaningful with parity enabled).
    if (PBITS != 0) begin
      send_frame(8'h07, 1'b0, 1'b0, 1);
      send_frame(8'h07, 1'b0, 1'b1, 1);
      drain("t6");
    end

    // Randomized frames: random data, occasional bad stop / bad parity,
    // random idle gaps (a low stop bit needs idle before the next start).
    for (int k = 0; k < 30; k++) begin
      bad_s = ($urandom_range(0, 3) == 0);
      bad_p = ($urandom_range(0, 3) == 0);
      gap   = $urandom_range(0, 2);
      if (bad_s && gap == 0) gap = 1;
      send_frame(8'($urandom), bad_s, bad_p, gap);
    end
    line(1'b1, 2 * CPB);
    drain("rand");
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
